// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N_CH-input arbiter feeding a single registered output slot.
// MODE=0 picks the lowest-indexed requester; MODE=1 rotates priority with a
// pointer that advances past the channel that last won. One word per cycle
// sustained: the slot can drain and refill on the same edge.
module rr_arb_mux #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DW-1:0]       in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(N_CH)-1:0]  out_ch,
  input  logic                     out_ready
);

  localparam int CW = $clog2(N_CH);

  logic [CW-1:0]   ptr;
  logic [N_CH-1:0] grant;
  logic [CW-1:0]   gnt_idx;
  logic            any_req;
  logic            slot_open;
  logic            in_xfer;
  logic [DW-1:0]   sel_data;
  logic            found;
  int              base;
  int              idx;

  // Priority search starting at ptr (or 0 in fixed mode), wrapping once.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    base    = (MODE == 1) ? int'(ptr) : 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = base + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && in_valid[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = CW'(idx);
      end
    end
  end

  // Handshake qualifiers; rst_n gating keeps in_ready low during reset.
  always_comb begin
    any_req   = |in_valid;
    slot_open = rst_n && (!out_valid || out_ready);
    in_xfer   = slot_open && any_req;
    in_ready  = grant & {N_CH{slot_open}};
    sel_data  = in_data[gnt_idx*DW +: DW];
  end

  // Output slot: refill whenever open, hold data/index when nothing arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (slot_open) begin
      out_valid <= any_req;
      if (any_req) begin
        out_data <= sel_data;
        out_ch   <= gnt_idx;
      end
    end
  end

  // Round-robin pointer moves only on an accepted input word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (MODE == 1 && in_xfer) begin
      if (gnt_idx == CW'(N_CH - 1)) ptr <= '0;
      else                          ptr <= gnt_idx + CW'(1);
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: round-robin instance plus a fixed-priority instance on the
// same stimulus, expectations hand-derived.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic [3:0]  in_ready, in_ready_fp;
  logic        out_valid, out_valid_fp;
  logic [7:0]  out_data, out_data_fp;
  logic [1:0]  out_ch, out_ch_fp;

  int n_chk = 0;
  int n_fail = 0;

  rr_arb_mux #(.N_CH(4), .DW(8), .MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready)
  );

  rr_arb_mux #(.N_CH(4), .DW(8), .MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_fp), .out_valid(out_valid_fp), .out_data(out_data_fp),
    .out_ch(out_ch_fp), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] ch, input logic [7:0] d);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_ch"}, 64'(out_ch), 64'(ch));
    chk({tag, "_data"}, 64'(out_data), 64'(d));
  endtask

  initial begin
    logic [1:0] exp_ch;
    logic [1:0] rr_seq [4];
    rr_seq[0] = 2'd1; rr_seq[1] = 2'd2; rr_seq[2] = 2'd3; rr_seq[3] = 2'd1;

    // Reset state, with a request pending to prove in_ready is gated.
    in_valid = 4'b0100;
    in_data  = 32'h00A5_0000;
    #3;
    step();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_ch", 64'(out_ch), 64'(0));
    chk("rst_ptr", 64'(dut.ptr), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));

    // Single channel, first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("single_in_ready", 64'(in_ready), 64'(4'b0100));
    step();
    chk_out("single", 2'd2, 8'hA5);
    chk("single_ptr", 64'(dut.ptr), 64'(3));
    in_valid = 4'b0000;
    step();
    chk("idle_valid", 64'(out_valid), 64'(0));
    chk("idle_hold_data", 64'(out_data), 64'(8'hA5));
    chk("idle_hold_ch", 64'(out_ch), 64'(2));

    // Fairness from ptr=0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    in_data  = 32'h4030_2010;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_ch = 2'(i % 4);
      step();
      chk_out($sformatf("rr%0d", i), exp_ch, 8'((int'(exp_ch) + 1) * 16));
    end
    chk("rr_ptr", 64'(dut.ptr), 64'(1));

    // Backpressure: ch0 word held, nothing accepted, ptr frozen.
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready0", 64'(in_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("bp%0d", i), 2'd0, 8'h10);
      chk($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'(0));
      chk($sformatf("bp%0d_ptr", i), 64'(dut.ptr), 64'(1));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_in_ready", 64'(in_ready), 64'(4'b0010));
    step();
    chk_out("bp_rel", 2'd1, 8'h20);
    chk("bp_rel_ptr", 64'(dut.ptr), 64'(2));

    // Reset between edges while stalled.
    out_ready = 1'b0;
    step();
    chk_out("stall", 2'd1, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_data", 64'(out_data), 64'(0));
    chk("mrst_ch", 64'(out_ch), 64'(0));
    chk("mrst_ptr", 64'(dut.ptr), 64'(0));
    chk("mrst_in_ready", 64'(in_ready), 64'(0));

    // Pointer wrap: move ptr to 3, then 3 and 0 compete.
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 4'b0100;
    step();
    chk_out("pre_wrap", 2'd2, 8'h30);
    chk("pre_wrap_ptr", 64'(dut.ptr), 64'(3));
    in_valid = 4'b1001;
    #1;
    chk("wrap_in_ready", 64'(in_ready), 64'(4'b1000));
    step();
    chk_out("wrap", 2'd3, 8'h40);
    chk("wrap_ptr", 64'(dut.ptr), 64'(0));
    step();
    chk_out("wrap_next", 2'd0, 8'h10);
    chk("wrap_next_ptr", 64'(dut.ptr), 64'(1));

    // Fixed priority vs round-robin on the same request pattern.
    in_valid = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fp%0d_in_ready", i), 64'(in_ready_fp), 64'(4'b0010));
      step();
      chk($sformatf("fp%0d_valid", i), 64'(out_valid_fp), 64'(1));
      chk($sformatf("fp%0d_ch", i), 64'(out_ch_fp), 64'(1));
      chk($sformatf("fp%0d_data", i), 64'(out_data_fp), 64'(8'h20));
      chk_out($sformatf("rr_mix%0d", i), rr_seq[i], 8'((int'(rr_seq[i]) + 1) * 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
